// File: rtl/qpsk_dibit_framer.sv
// qpsk_dibit_framer
// Serial-to-dibit front end for the QPSK sine/cosine modulator. Incoming bits
// are paired (first bit -> E/I, second bit -> O/Q), queued in a small FIFO and
// presented on E/O for exactly SAMPLES_PER_SYM sample ticks each. The block
// also produces the divided sample tick and a symbol-start pulse that the
// modulator uses to restart its LUT index.
//
// Ports:
//   Clk          system clock, rising edge
//   Rst_n        asynchronous active-low reset
//   Din          serial data bit
//   Din_valid    Din is valid this cycle
//   Din_ready    block accepts Din this cycle (from registered state only)
//   E, O         even (I) / odd (Q) bit of the current symbol (1/1 when idle)
//   sym_valid    E/O carry a real symbol
//   sym_start    one-cycle pulse when a new symbol is loaded onto E/O
//   sample_tick  one-cycle pulse every CLK_DIV clocks
//   underrun     one-cycle pulse when a symbol ends with the FIFO empty
//   fifo_level   number of buffered dibits
module qpsk_dibit_framer #(
  parameter int CLK_DIV         = 16,
  parameter int SAMPLES_PER_SYM = 100,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic                              Din,
  input  logic                              Din_valid,
  output logic                              Din_ready,
  output logic                              E,
  output logic                              O,
  output logic                              sym_valid,
  output logic                              sym_start,
  output logic                              sample_tick,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_SYM - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // prescaler
  logic [DW-1:0] div_cnt_r;
  logic          tick_r;

  // bit packing and FIFO
  logic          phase_r;
  logic          e_pend_r;
  logic [1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [1:0]    rd_dibit_s;

  // symbol FSM
  state_t        state_r;
  state_t        state_s;
  logic [SW-1:0] samp_cnt_r;
  logic [SW-1:0] samp_cnt_s;
  logic          e_r, e_s;
  logic          o_r, o_s;
  logic          valid_r, valid_s;
  logic          start_r, start_s;
  logic          underrun_r, underrun_s;

  // Refusal only applies to the second bit of a pair: the first bit has a
  // dedicated holding register, so it is always accepted. No bypass on pop.
  assign ready_s      = (!phase_r) || (level_r < LVL_FULL);
  assign accept_s     = Din_valid && ready_s;
  assign push_s       = accept_s && phase_r;
  assign fifo_empty_s = (level_r == '0);
  assign rd_dibit_s   = fifo_mem_r[rd_ptr_r];

  assign Din_ready   = ready_s;
  assign E           = e_r;
  assign O           = o_r;
  assign sym_valid   = valid_r;
  assign sym_start   = start_r;
  assign sample_tick = tick_r;
  assign underrun    = underrun_r;
  assign fifo_level  = level_r;

  // Free-running clock divider; the tick is registered off the terminal count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end
      tick_r <= (div_cnt_r == DIV_LAST);
    end
  end

  // Pair phase and pending E bit; reset drops any half-built pair.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase_r  <= 1'b0;
      e_pend_r <= 1'b0;
    end else if (accept_s) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        e_pend_r <= Din;
      end
    end
  end

  // FIFO storage; contents are qualified by level_r so no reset is needed.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {e_pend_r, Din};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Symbol FSM state and registered symbol outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= ST_IDLE;
      samp_cnt_r <= '0;
      e_r        <= 1'b1;
      o_r        <= 1'b1;
      valid_r    <= 1'b0;
      start_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      samp_cnt_r <= samp_cnt_s;
      e_r        <= e_s;
      o_r        <= o_s;
      valid_r    <= valid_s;
      start_r    <= start_s;
      underrun_r <= underrun_s;
    end
  end

  // Next-state logic: symbols only start/end on a sample tick, so every
  // symbol spans exactly SAMPLES_PER_SYM ticks.
  always_comb begin
    state_s    = state_r;
    samp_cnt_s = samp_cnt_r;
    e_s        = e_r;
    o_s        = o_r;
    valid_s    = valid_r;
    start_s    = 1'b0;
    underrun_s = 1'b0;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        samp_cnt_s = '0;
        e_s        = 1'b1;
        o_s        = 1'b1;
        valid_s    = 1'b0;
        if (tick_r && !fifo_empty_s) begin
          pop_s   = 1'b1;
          e_s     = rd_dibit_s[1];
          o_s     = rd_dibit_s[0];
          valid_s = 1'b1;
          start_s = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_r) begin
          if (samp_cnt_r == SAMP_LAST) begin
            samp_cnt_s = '0;
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              e_s     = rd_dibit_s[1];
              o_s     = rd_dibit_s[0];
              valid_s = 1'b1;
              start_s = 1'b1;
              state_s = ST_RUN;
            end else begin
              e_s        = 1'b1;
              o_s        = 1'b1;
              valid_s    = 1'b0;
              underrun_s = 1'b1;
              state_s    = ST_IDLE;
            end
          end else begin
            samp_cnt_s = samp_cnt_r + SW'(1);
          end
        end else begin
          samp_cnt_s = samp_cnt_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        samp_cnt_s = '0;
        e_s        = 1'b1;
        o_s        = 1'b1;
        valid_s    = 1'b0;
      end
    endcase
  end

endmodule
